// File: rtl/cpu_player_pkg.sv
// Shared types and constants for the computer opponent: FSM encoding and
// the 10-bit XNOR LFSR definition used by the pacing draw.
package cpu_player_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    localparam int LFSR_W  = 10;
    localparam int SPEED_W = 9;
    localparam int TAP_HI  = 9;
    localparam int TAP_LO  = 6;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 10'd0;

    // XNOR feedback keeps the all-zero seed legal; all-ones is the lock-up state.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ~(cur[TAP_HI] ^ cur[TAP_LO])};
    endfunction

endpackage

// File: rtl/cpu_player_if.sv
// Game-side signal bundle of the computer opponent: enable/speed in,
// press pulse and LFSR observation out.
interface cpu_player_if;

    logic                                 enable;
    logic [cpu_player_pkg::SPEED_W-1:0]   speed;
    logic                                 press;
    logic [cpu_player_pkg::LFSR_W-1:0]    lfsr_q;

    modport master (
        output enable,
        output speed,
        input  press,
        input  lfsr_q
    );

    modport slave (
        input  enable,
        input  speed,
        output press,
        output lfsr_q
    );

endinterface

// File: rtl/cpu_player_lfsr10.sv
// Step-enabled 10-bit LFSR; holds its value whenever step is low.
module lfsr10
    import cpu_player_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q;
    logic [LFSR_W-1:0] q_d;

    // Next-state selection: advance on step, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (step) begin
            q_d = lfsr_next(q_q);
        end else begin
            q_d = q_q;
        end
    end

    // State register, cleared to the seed by the asynchronous reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/cpu_player.sv
// Computer opponent: once per pacing tick draws an LFSR value against the
// speed threshold and emits a single-cycle press, followed by a one-tick hold-off.
module cpu_player
    import cpu_player_pkg::*;
#(
    parameter int TICK_CYCLES = 5_000_000
) (
    input  logic        Clock,
    input  logic        Reset,
    cpu_player_if.slave bus
);

    localparam int CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    state_e            state_q;
    state_e            state_d;
    logic              press_q;
    logic              press_d;
    logic              tick_s;
    logic              hit_s;
    logic [LFSR_W-1:0] lfsr_s;

    assign tick_s = bus.enable & (count_q == CNT_LAST);
    // Draw uses the pre-advance LFSR value, speed zero-extended.
    assign hit_s  = ({1'b0, bus.speed} > lfsr_s);

    lfsr10 u_lfsr (
        .Clock (Clock),
        .Reset (Reset),
        .step  (tick_s),
        .q     (lfsr_s)
    );

    // Pacing counter: wraps at TICK_CYCLES-1, parked at zero while disabled.
    always_comb begin
        count_d = count_q;
        if (!bus.enable) begin
            count_d = CNT_ZERO;
        end else if (count_q == CNT_LAST) begin
            count_d = CNT_ZERO;
        end else begin
            count_d = count_q + CNT_ONE;
        end
    end

    // Next-state logic; press is the registered image of the FIRE state.
    always_comb begin
        state_d = state_q;
        press_d = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick_s && hit_s) begin
                        state_d = FIRE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FIRE: begin
                    state_d = HOLDOFF;
                end
                HOLDOFF: begin
                    if (tick_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLDOFF;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        press_d = (state_d == FIRE);
    end

    // State, counter and output registers with asynchronous clear.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count_q <= CNT_ZERO;
            state_q <= IDLE;
            press_q <= 1'b0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            press_q <= press_d;
        end
    end

    assign bus.press  = press_q;
    assign bus.lfsr_q = lfsr_s;

endmodule

// File: tb/tb_cpu_player.sv
// Self-checking bench for cpu_player: a cycle model feeds a scoreboard queue
// that is compared against the DUT every cycle, plus directed boundary checks.
module tb_cpu_player;

    localparam int T = 4;

    typedef struct packed {
        logic       press;
        logic [9:0] lfsr;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset;

    cpu_player_if bus ();

    cpu_player #(.TICK_CYCLES(T)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    exp_t       sb_q[$];
    int         n_pass   = 0;
    int         n_checks = 0;
    int         m_cnt    = 0;
    logic [9:0] m_lfsr   = 10'd0;
    int         m_state  = 0;
    int         cyc      = 0;
    int         gcyc     = 0;
    int         last_press;
    logic [9:0] seq_tbl [9];

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, expv, $time);
        end
    endtask

    // Reference behaviour, evaluated once per rising edge with the inputs held before it.
    task automatic model_step();
        logic       tick;
        logic       hit;
        int         ns;
        logic [9:0] nl;
        exp_t       e;
        if (!Reset) begin
            m_cnt   = 0;
            m_lfsr  = 10'd0;
            m_state = 0;
        end else begin
            tick = bus.enable && (m_cnt == T - 1);
            hit  = ({1'b0, bus.speed} > m_lfsr);
            nl   = tick ? {m_lfsr[8:0], ~(m_lfsr[9] ^ m_lfsr[6])} : m_lfsr;
            if (!bus.enable)       ns = 0;
            else if (m_state == 0) ns = (tick && hit) ? 1 : 0;
            else if (m_state == 1) ns = 2;
            else                   ns = tick ? 0 : 2;
            m_cnt   = !bus.enable ? 0 : ((m_cnt == T - 1) ? 0 : m_cnt + 1);
            m_lfsr  = nl;
            m_state = ns;
        end
        e.press = (m_state == 1);
        e.lfsr  = m_lfsr;
        sb_q.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge Clock);
        model_step();
        cyc++;
        gcyc++;
        @(negedge Clock);
        if (sb_q.size() == 0) begin
            chk_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk_eq("sb_press", bus.press, e.press);
            chk_eq("sb_lfsr", bus.lfsr_q, e.lfsr);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        run(2);
        Reset = 1'b1;
        cyc = 0;
    endtask

    initial begin
        seq_tbl = '{10'd0, 10'd1, 10'd3, 10'd7, 10'd15, 10'd31, 10'd63, 10'd127, 10'd254};
        Reset      = 1'b0;
        bus.enable = 1'b0;
        bus.speed  = 9'd0;
        @(negedge Clock);
        chk_eq("rst_press", bus.press, 32'd0);
        chk_eq("rst_lfsr", bus.lfsr_q, 32'd0);
        chk_eq("rst_count", dut.count_q, 32'd0);
        run(2);

        // LFSR sequence with speed 0: never fires
        bus.enable = 1'b1;
        Reset = 1'b1;
        cyc = 0;
        run(3);
        chk_eq("lfsr_seq0", bus.lfsr_q, seq_tbl[0]);
        for (int k = 1; k < 9; k++) begin
            run(4);
            chk_eq("lfsr_seq", bus.lfsr_q, seq_tbl[k]);
        end

        // Fire / hold-off with speed 511
        bus.speed = 9'd511;
        do_reset();
        run(3);
        chk_eq("tick0_nopress", bus.press, 32'd0);
        run(1);
        chk_eq("fire1", bus.press, 32'd1);
        run(1);
        chk_eq("fire1_width", bus.press, 32'd0);
        run(3);
        chk_eq("holdoff_skip", bus.press, 32'd0);
        run(4);
        chk_eq("fire2", bus.press, 32'd1);

        // Enable dropped during hold-off
        run(2);
        bus.enable = 1'b0;
        run(10);
        chk_eq("dis_lfsr_frozen", bus.lfsr_q, 32'd7);
        chk_eq("dis_count", dut.count_q, 32'd0);
        chk_eq("dis_press", bus.press, 32'd0);
        bus.enable = 1'b1;
        cyc = 0;
        run(3);
        chk_eq("reen_nopress", bus.press, 32'd0);
        run(1);
        chk_eq("reen_fire", bus.press, 32'd1);
        chk_eq("reen_lfsr", bus.lfsr_q, 32'd15);

        // Asynchronous reset while press is high
        Reset = 1'b0;
        #1;
        chk_eq("areset_press", bus.press, 32'd0);
        chk_eq("areset_lfsr", bus.lfsr_q, 32'd0);
        chk_eq("areset_count", dut.count_q, 32'd0);
        run(2);
        Reset = 1'b1;
        cyc = 0;
        run(3);
        chk_eq("restart_count", dut.count_q, 32'd3);
        run(1);
        chk_eq("restart_fire", bus.press, 32'd1);

        // Threshold: speed 2 hits lfsr 1, misses lfsr 3
        bus.speed = 9'd0;
        do_reset();
        run(4);
        bus.speed = 9'd2;
        run(4);
        chk_eq("thr_hit_lfsr1", bus.press, 32'd1);
        bus.speed = 9'd0;
        do_reset();
        run(8);
        bus.speed = 9'd2;
        run(4);
        chk_eq("thr_miss_lfsr3", bus.press, 32'd0);
        chk_eq("thr_miss_lfsr", bus.lfsr_q, 32'd7);

        // Random speed over 2000 ticks: press spacing invariant
        do_reset();
        last_press = -100000;
        for (int i = 0; i < 2000 * T; i++) begin
            if (i % 4 == 0) bus.speed = 9'($urandom_range(0, 511));
            cycle();
            if (bus.press === 1'b1) begin
                chk_eq("press_gap", 32'((gcyc - last_press) >= 2 * T), 32'd1);
                last_press = gcyc;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
